memory_loader: RTL and testbench
================================

# memory_loader

Boot-time loader sitting directly upstream of the word-addressed program/data memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes them to consecutive memory addresses starting at a fixed base, keeps a running checksum, and holds `busy` high so the CPU stays parked until the image is in place.

## Interface
- `SIZE`, 256: number of 32-bit words in the downstream memory; addresses 0..SIZE-1 are valid.
- `BASE`, 0: first word address written by every load.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE.
- `word_count`  in  32  number of words to load; latched on accepted `start`.
- `byte_valid`  in  1  upstream byte present.
- `byte_data`  in  8  upstream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_write_enable`  out  1  write strobe to memory.
- `mem_address`  out  32  word address to memory.
- `mem_data_in`  out  32  write data to memory.
- `busy`  out  1  load in progress; CPU hold.
- `done`  out  1  sticky: last request finished (success or error).
- `error`  out  1  sticky: last request rejected (image does not fit).
- `checksum`  out  32  sum mod 2^32 of all words written by the current/last load.

## Operation
- States: IDLE, COLLECT, WRITE.
- IDLE:
  - `byte_ready`=0.
  - `start`=1 clears `done`, `error` and `checksum` in the same edge.
  - `word_count`==0: set `done`, stay in IDLE.
  - Fit check uses 33-bit arithmetic: BASE+word_count > SIZE sets `error`=1 and `done`=1, stays in IDLE, and performs no write.
  - Otherwise, latch remaining=word_count, address=BASE and lane=0, set `busy`, and go to COLLECT.
- COLLECT:
  - `byte_ready`=1.
  - A byte is transferred on each edge with `byte_valid`&&`byte_ready`.
  - The byte goes to lane `lane`: lane 0 = bits 7:0 and lane 3 = bits 31:24, so the first byte received is least significant.
  - lane increments after each transfer.
  - The transfer into lane 3 moves the block to WRITE with lane=0.
  - `byte_valid`=0 simply waits; there is no timeout.
- WRITE:
  - Lasts exactly one cycle, with `byte_ready`=0 and `mem_write_enable`=1.
  - `mem_address` = current address; `mem_data_in` = the assembled word.
  - The memory captures the word on the edge that ends this cycle.
  - On that edge: checksum += word (wraps mod 2^32), address += 1, remaining -= 1.
  - remaining now 0: clear `busy`, set `done`, go to IDLE. Otherwise go to COLLECT.
- `start` while `busy` is ignored.
- Outside WRITE, `mem_write_enable`=0.
  - `mem_address` holds the last registered address.
  - `mem_data_in` holds the partially assembled word.
- The fit check guarantees that no write ever targets an address ≥ SIZE.

## Timing
- Reset values (asynchronous, on `reset_n`=0): state IDLE, `byte_ready`=0, `mem_write_enable`=0, `mem_address`=BASE, `mem_data_in`=0, `busy`=0, `done`=0, `error`=0, `checksum`=0, lane=0.
- `start` acceptance: `busy` (or `done`/`error`) becomes visible the cycle after the `start` edge. `byte_ready` rises in that same cycle.
- Write latency: `mem_write_enable` is high in the cycle immediately after the edge that accepted byte 3.
- Throughput: at most one word per 5 cycles (4 byte cycles plus 1 write cycle).
- Completion: `done` rises and `busy` falls on the edge ending the final WRITE cycle. `checksum` is final in that same cycle.
- Reset mid-load: the load is aborted immediately and any partial word is discarded. Memory words already written are kept, because the memory has no reset. The next `start` reloads from BASE.
- `byte_ready` depends only on state, never combinationally on `byte_valid`.

## Test plan
- Reset: hold `reset_n`=0 with random inputs -> all outputs at reset values, and `byte_ready`=0 throughout.
- Two-word load, BASE=0: `word_count`=2, then back-to-back bytes 78 56 34 12 EF BE AD DE.
  - Required: mem[0]=0x12345678 and mem[1]=0xDEADBEEF.
  - `mem_write_enable` is high on exactly 2 cycles, 5 cycles apart.
  - End state: `checksum`=0xF0E21567, `done`=1, `busy`=0.
- Stalled stream: same bytes with random gaps in `byte_valid` -> same memory contents and checksum, each write exactly one cycle after its 4th byte.
- Bounds, SIZE=256, BASE=0:
  - `word_count`=257 -> `error`=1, `done`=1, no write, `busy` never high.
  - `word_count`=256 -> accepted; the last write goes to address 255.
- Corner requests:
  - `word_count`=0 -> `done`=1 the next cycle with no write.
  - A second `start` pulse during a load is ignored, and the original count completes.
- Mid-load reset: drop `reset_n` after 6 bytes of a 2-word load.
  - Required: mem[0] written and mem[1] untouched; outputs at reset values.
  - A new 1-word load then writes to address BASE.

Source files
------------

// File: rtl/memory_loader.sv
// memory_loader: boot-time byte-stream loader. Assembles little-endian
// 32-bit words from a valid/ready byte stream, writes them to consecutive
// word addresses starting at BASE, and keeps a running checksum while
// holding busy high so the CPU stays parked.
module memory_loader #(
  parameter int unsigned SIZE = 256,
  parameter int unsigned BASE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  state_t      r_state,     w_state_next;
  logic [31:0] r_remaining, w_remaining_next;
  logic [31:0] r_address,   w_address_next;
  logic [31:0] r_word,      w_word_next;
  logic [31:0] r_checksum,  w_checksum_next;
  logic [1:0]  r_lane,      w_lane_next;
  logic        r_busy,      w_busy_next;
  logic        r_done,      w_done_next;
  logic        r_error,     w_error_next;

  // Fit check is done in 33 bits so a huge word_count cannot wrap past SIZE.
  logic [32:0] w_end;
  logic        w_too_big;
  assign w_end     = 33'(BASE) + {1'b0, word_count};
  assign w_too_big = (w_end > 33'(SIZE));

  // State and datapath registers; reset aborts any load and drops the partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_address   <= 32'(BASE);
      r_word      <= '0;
      r_checksum  <= '0;
      r_lane      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_address   <= w_address_next;
      r_word      <= w_word_next;
      r_checksum  <= w_checksum_next;
      r_lane      <= w_lane_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_error     <= w_error_next;
    end
  end

  // Next-state and next-value logic; everything holds unless a state acts on it.
  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_address_next   = r_address;
    w_word_next      = r_word;
    w_checksum_next  = r_checksum;
    w_lane_next      = r_lane;
    w_busy_next      = r_busy;
    w_done_next      = r_done;
    w_error_next     = r_error;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_done_next     = 1'b0;
          w_error_next    = 1'b0;
          w_checksum_next = '0;
          if (word_count == 32'd0) begin
            w_done_next = 1'b1;
          end else if (w_too_big) begin
            w_error_next = 1'b1;
            w_done_next  = 1'b1;
          end else begin
            w_remaining_next = word_count;
            w_address_next   = 32'(BASE);
            w_lane_next      = 2'd0;
            w_busy_next      = 1'b1;
            w_state_next     = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (byte_valid) begin
          // First byte lands in bits 7:0 (little-endian assembly).
          w_word_next[{r_lane, 3'b000} +: 8] = byte_data;
          w_lane_next = r_lane + 2'd1;
          if (r_lane == 2'd3) begin
            w_state_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        w_checksum_next  = r_checksum + r_word;
        w_address_next   = r_address + 32'd1;
        w_remaining_next = r_remaining - 32'd1;
        if (r_remaining == 32'd1) begin
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_COLLECT;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Handshake and memory strobes are decoded from state only.
  assign byte_ready       = (r_state == S_COLLECT);
  assign mem_write_enable = (r_state == S_WRITE);
  assign mem_address      = r_address;
  assign mem_data_in      = r_word;
  assign busy             = r_busy;
  assign done             = r_done;
  assign error            = r_error;
  assign checksum         = r_checksum;

endmodule

// File: tb/tb_memory_loader.sv
// Directed self-checking bench for memory_loader (SIZE=256, BASE=0).
module tb_memory_loader;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  int checks = 0;
  int errors = 0;

  memory_loader #(.SIZE(256), .BASE(0)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .word_count       (word_count),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_ready       (byte_ready),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .checksum         (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model and observation log; written only by this monitor.
  logic [31:0] tb_mem [0:255];
  logic [31:0] wr_log_data [0:1023];
  int          wr_log_cyc  [0:1023];
  int          cyc = 0;
  int          wr_count = 0;
  int          nbytes = 0;
  int          last4 = -10;
  int          lat_bad = 0;
  int          busy_cnt = 0;
  int          rdy_in_reset = 0;
  logic [31:0] last_addr = 32'hFFFF_FFFF;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!reset_n) begin
      nbytes = 0;
      if (byte_ready) rdy_in_reset = rdy_in_reset + 1;
    end else begin
      if (mem_write_enable) begin
        tb_mem[mem_address[7:0]] = mem_data_in;
        wr_log_data[wr_count[9:0]] = mem_data_in;
        wr_log_cyc[wr_count[9:0]]  = cyc;
        wr_count  = wr_count + 1;
        last_addr = mem_address;
        if (cyc != last4 + 1) lat_bad = lat_bad + 1;
      end
      if (byte_valid && byte_ready) begin
        nbytes = nbytes + 1;
        if (nbytes % 4 == 0) last4 = cyc;
      end
      if (busy) busy_cnt = busy_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"}, {27'd0, byte_ready, mem_write_enable, busy, done, error}, 32'd0);
    check({tag, "_addr"}, mem_address, 32'd0);
    check({tag, "_data"}, mem_data_in, 32'd0);
    check({tag, "_csum"}, checksum, 32'd0);
  endtask

  task automatic do_start(input logic [31:0] n);
    start = 1'b1;
    word_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for byte_ready, offers one byte for one cycle.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    for (int g = 0; g < gap; g++) @(negedge clk);
    k = 0;
    while (!byte_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!byte_ready) check("byte_ready_timeout", 32'd0, 32'd1);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = $urandom_range(0, 255);
  endtask

  task automatic wait_not_busy();
    int k;
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("busy_timeout", 32'd1, 32'd0);
  endtask

  logic [7:0] img [0:7];
  int base;
  int bc;
  logic [31:0] sentinel;

  initial begin
    img[0] = 8'h78; img[1] = 8'h56; img[2] = 8'h34; img[3] = 8'h12;
    img[4] = 8'hEF; img[5] = 8'hBE; img[6] = 8'hAD; img[7] = 8'hDE;
    reset_n = 1'b1;
    start = 1'b0;
    word_count = 32'd0;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    #1 reset_n = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      start      = 1'($urandom_range(0, 1));
      word_count = $urandom;
      byte_valid = 1'($urandom_range(0, 1));
      byte_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      check_reset_outputs("reset");
    end
    check("ready_in_reset", rdy_in_reset, 0);
    start = 1'b0;
    byte_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Two-word back-to-back load.
    base = wr_count;
    do_start(32'd2);
    check("start_busy", {30'd0, busy, byte_ready}, 32'd3);
    for (int i = 0; i < 8; i++) send_byte(img[i], 0);
    check("wr_en_after_byte3", {31'd0, mem_write_enable}, 32'd1);
    check("wr_addr_word1", mem_address, 32'd1);
    @(negedge clk);
    check("two_wr_count", wr_count - base, 2);
    check("two_wr_spacing", wr_log_cyc[base + 1] - wr_log_cyc[base], 5);
    check("two_mem0", tb_mem[0], 32'h12345678);
    check("two_mem1", tb_mem[1], 32'hDEADBEEF);
    check("two_csum", checksum, 32'hF0E21567);
    check("two_flags", {29'd0, busy, done, error}, 32'b010);

    // Same image with random stalls.
    base = wr_count;
    do_start(32'd2);
    check("stall_csum_cleared", checksum, 32'd0);
    check("stall_done_cleared", {31'd0, done}, 32'd0);
    for (int i = 0; i < 8; i++) send_byte(img[i], $urandom_range(0, 3));
    wait_not_busy();
    check("stall_wr_count", wr_count - base, 2);
    check("stall_w0", wr_log_data[base], 32'h12345678);
    check("stall_w1", wr_log_data[base + 1], 32'hDEADBEEF);
    check("stall_csum", checksum, 32'hF0E21567);
    check("stall_done", {31'd0, done}, 32'd1);
    check("write_latency", lat_bad, 0);

    // Oversize request: rejected, no write, never busy.
    base = wr_count;
    bc = busy_cnt;
    do_start(32'd257);
    check("ovf_flags", {29'd0, busy, done, error}, 32'b011);
    check("ovf_ready", {31'd0, byte_ready}, 32'd0);
    repeat (4) @(negedge clk);
    check("ovf_no_write", wr_count - base, 0);
    check("ovf_busy_cnt", busy_cnt - bc, 0);

    // Exactly full memory: word i carries value i.
    base = wr_count;
    do_start(32'd256);
    check("full_error_cleared", {30'd0, done, error}, 32'd0);
    for (int w = 0; w < 256; w++) begin
      send_byte(8'(w), 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
    end
    wait_not_busy();
    check("full_wr_count", wr_count - base, 256);
    check("full_last_addr", last_addr, 32'd255);
    check("full_mem255", tb_mem[255], 32'd255);
    check("full_mem17", tb_mem[17], 32'd17);
    check("full_csum", checksum, 32'h00007F80);
    check("full_flags", {29'd0, busy, done, error}, 32'b010);

    // Zero-length request.
    base = wr_count;
    do_start(32'd0);
    check("zero_flags", {29'd0, busy, done, error}, 32'b010);
    check("zero_csum", checksum, 32'd0);
    repeat (2) @(negedge clk);
    check("zero_no_write", wr_count - base, 0);

    // Second start during a load is ignored.
    base = wr_count;
    do_start(32'd2);
    send_byte(img[0], 0);
    send_byte(img[1], 0);
    do_start(32'd5);
    for (int i = 2; i < 8; i++) send_byte(img[i], 0);
    wait_not_busy();
    repeat (8) @(negedge clk);
    check("restart_wr_count", wr_count - base, 2);
    check("restart_busy", {31'd0, busy}, 32'd0);
    check("restart_csum", checksum, 32'hF0E21567);

    // Reset after 6 bytes of a 2-word load.
    sentinel = tb_mem[1];
    base = wr_count;
    do_start(32'd2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check("midrst_wr_count", wr_count - base, 1);
    check("midrst_mem0", tb_mem[0], 32'h44332211);
    check("midrst_mem1", tb_mem[1], sentinel);
    reset_n = 1'b1;
    @(negedge clk);
    base = wr_count;
    do_start(32'd1);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    wait_not_busy();
    check("reload_wr_count", wr_count - base, 1);
    check("reload_addr", last_addr, 32'd0);
    check("reload_mem0", tb_mem[0], 32'h04030201);
    check("reload_csum", checksum, 32'h04030201);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog keeps the run bounded.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
